// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic light controller and its monitor:
// lamp patterns, tracked-phase codes, fault causes and FSM states.
package traffic_light_pkg;

  // Lamp patterns as driven by the controller
  localparam logic [3:0] LAMP_P0     = 4'b1000;
  localparam logic [3:0] LAMP_P1     = 4'b0100;
  localparam logic [3:0] LAMP_P2     = 4'b0010;
  localparam logic [3:0] LAMP_ALL_ON = 4'b1111;

  // Tracked phase as reported on the phase output
  localparam logic [1:0] PH_P0   = 2'd0;
  localparam logic [1:0] PH_P1   = 2'd1;
  localparam logic [1:0] PH_P2   = 2'd2;
  localparam logic [1:0] PH_IDLE = 2'd3;

  // Fault causes; only the first one after a clear is kept
  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ILLEGAL   = 3'd1;
  localparam logic [2:0] FC_BAD_TRANS = 3'd2;
  localparam logic [2:0] FC_TOO_SHORT = 3'd3;
  localparam logic [2:0] FC_TOO_LONG  = 3'd4;

  // Monitor FSM states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_P0    = 3'd1;
  localparam state_t ST_P1    = 3'd2;
  localparam state_t ST_P2    = 3'd3;
  localparam state_t ST_FAULT = 3'd4;

  // Decoded lamp class; the three phase classes share values with PH_*
  typedef enum logic [2:0] {
    LC_P0      = 3'd0,
    LC_P1      = 3'd1,
    LC_P2      = 3'd2,
    LC_ALL_ON  = 3'd3,
    LC_ILLEGAL = 3'd4
  } lamp_cls_t;

  function automatic lamp_cls_t decode_lamp(input logic [3:0] l);
    case (l)
      LAMP_P0:     return LC_P0;
      LAMP_P1:     return LC_P1;
      LAMP_P2:     return LC_P2;
      LAMP_ALL_ON: return LC_ALL_ON;
      default:     return LC_ILLEGAL;
    endcase
  endfunction

  // Legal successor of a running phase (P0->P1->P2->P0)
  function automatic logic [1:0] succ_phase(input logic [1:0] p);
    case (p)
      PH_P0:   return PH_P1;
      PH_P1:   return PH_P2;
      PH_P2:   return PH_P0;
      default: return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_dwell_counter.sv
// Saturating dwell counter: clear has priority, then load-to-1,
// then increment; otherwise the count holds.
module traffic_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count update; saturates at all-ones so it can never wrap
  always_ff @(posedge clk) begin
    if (i_clr)
      r_cnt <= '0;
    else if (i_load1)
      r_cnt <= CNT_W'(1);
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches the lamp pattern from the traffic controller, tracks the
// P0->P1->P2 rotation, checks per-phase dwell limits, counts completed
// rounds and latches the first fault until cleared.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int MIN_DWELL = 3,
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic [3:0]       light,
  input  logic             clr,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] cycle_count,
  output logic             cycle_done,
  output logic             fault,
  output logic [2:0]       fault_code
);

  state_t           r_state;
  logic [1:0]       r_phase;
  logic [2:0]       r_code;
  logic             r_fault;
  logic             r_done;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] w_dwell;

  lamp_cls_t        w_cls;
  logic [1:0]       w_lph;
  state_t           w_nstate;
  logic [1:0]       w_nphase;
  logic [2:0]       w_ncode;
  logic             w_load1;
  logic             w_inc;
  logic             w_zero;
  logic             w_done;
  logic             w_cnt_clr;

  assign w_cls = decode_lamp(light);
  assign w_lph = w_cls[1:0];

  // Next-state decision for the sampled lamp pattern
  always_comb begin
    w_nstate = r_state;
    w_nphase = r_phase;
    w_ncode  = r_code;
    w_load1  = 1'b0;
    w_inc    = 1'b0;
    w_zero   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cls == LC_P0) begin
          w_nstate = ST_P0;
          w_nphase = PH_P0;
          w_load1  = 1'b1;
        end else if (w_cls == LC_ILLEGAL) begin
          w_nstate = ST_FAULT;
          w_ncode  = FC_ILLEGAL;
        end else if (w_cls != LC_ALL_ON) begin
          // P1/P2 without a preceding P0
          w_nstate = ST_FAULT;
          w_ncode  = FC_BAD_TRANS;
        end
      end
      ST_P0, ST_P1, ST_P2: begin
        if (w_cls == LC_ILLEGAL) begin
          w_nstate = ST_FAULT;
          w_ncode  = FC_ILLEGAL;
        end else if (w_cls == LC_ALL_ON) begin
          w_nstate = ST_IDLE;
          w_nphase = PH_IDLE;
          w_zero   = 1'b1;
        end else if (w_lph == r_phase) begin
          if (w_dwell == CNT_W'(MAX_DWELL)) begin
            w_nstate = ST_FAULT;
            w_ncode  = FC_TOO_LONG;
          end else begin
            w_inc = 1'b1;
          end
        end else if (w_lph == succ_phase(r_phase)) begin
          if (w_dwell < CNT_W'(MIN_DWELL)) begin
            w_nstate = ST_FAULT;
            w_ncode  = FC_TOO_SHORT;
          end else begin
            w_nstate = state_t'({1'b0, w_lph} + 3'd1);
            w_nphase = w_lph;
            w_load1  = 1'b1;
            w_done   = (r_phase == PH_P2);
          end
        end else begin
          w_nstate = ST_FAULT;
          w_ncode  = FC_BAD_TRANS;
        end
      end
      default: ; // FAULT: everything frozen until clr
    endcase
  end

  // Reset and clear both wipe the dwell count; ALL_ON returns it to zero
  assign w_cnt_clr = res | clr | w_zero;

  traffic_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk     (clk),
    .i_clr   (w_cnt_clr),
    .i_load1 (w_load1 & ~res & ~clr),
    .i_inc   (w_inc & ~res & ~clr),
    .o_cnt   (w_dwell)
  );

  // State, phase, fault and round bookkeeping; clr discards the sample
  always_ff @(posedge clk) begin
    if (res || clr) begin
      r_state  <= ST_IDLE;
      r_phase  <= PH_IDLE;
      r_code   <= FC_NONE;
      r_fault  <= 1'b0;
      r_done   <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_state <= w_nstate;
      r_phase <= w_nphase;
      r_code  <= w_ncode;
      r_fault <= (w_nstate == ST_FAULT);
      r_done  <= w_done;
      if (w_done && (r_cycles != '1))
        r_cycles <= r_cycles + 1'b1;
    end
  end

  assign phase       = r_phase;
  assign dwell       = w_dwell;
  assign cycle_count = r_cycles;
  assign cycle_done  = r_done;
  assign fault       = r_fault;
  assign fault_code  = r_code;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: the stimulus process drives one sample per cycle and
// queues the hand-computed outputs for it; the monitor pops and compares
// one entry after every rising edge.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] light = 4'b0000;
  logic [1:0] phase;
  logic [7:0] dwell;
  logic [7:0] cycle_count;
  logic       cycle_done;
  logic       fault;
  logic [2:0] fault_code;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_DWELL (3),
    .MAX_DWELL (16),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .res         (res),
    .light       (light),
    .clr         (clr),
    .phase       (phase),
    .dwell       (dwell),
    .cycle_count (cycle_count),
    .cycle_done  (cycle_done),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] dw;
    logic [7:0] cc;
    logic       dn;
    logic       flt;
    logic [2:0] code;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;

  // Drive one sample at the falling edge and queue its expected outputs
  task automatic step(input logic r, input logic c, input logic [3:0] l,
                      input int ph, input int dw, input int cc,
                      input int dn, input int flt, input int code,
                      input string nm);
    exp_t e;
    @(negedge clk);
    res   = r;
    clr   = c;
    light = l;
    e.ph   = 2'(ph);
    e.dw   = 8'(dw);
    e.cc   = 8'(cc);
    e.dn   = 1'(dn);
    e.flt  = 1'(flt);
    e.code = 3'(code);
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Expect the cleared/idle picture
  task automatic idle_step(input logic r, input logic c, input logic [3:0] l,
                           input string nm);
    step(r, c, l, 3, 0, 0, 0, 0, 0, nm);
  endtask

  // Monitor: compare one queued expectation after each rising edge
  initial begin
    exp_t  e;
    exp_t  g;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n = nm_q.pop_front();
        g.ph   = phase;
        g.dw   = dwell;
        g.cc   = cycle_count;
        g.dn   = cycle_done;
        g.flt  = fault;
        g.code = fault_code;
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL %s: got ph=%0d dw=%0d cc=%0d done=%0d flt=%0d code=%0d want ph=%0d dw=%0d cc=%0d done=%0d flt=%0d code=%0d",
                   n, g.ph, g.dw, g.cc, g.dn, g.flt, g.code,
                   e.ph, e.dw, e.cc, e.dn, e.flt, e.code);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset state
    idle_step(1, 0, 4'b0000, "reset");

    // One full legal round
    for (int i = 0; i < 3; i++) step(0, 0, 4'b1000, 0, i + 1, 0, 0, 0, 0, "A_p0");
    for (int i = 0; i < 3; i++) step(0, 0, 4'b0100, 1, i + 1, 0, 0, 0, 0, "A_p1");
    for (int i = 0; i < 3; i++) step(0, 0, 4'b0010, 2, i + 1, 0, 0, 0, 0, "A_p2");
    step(0, 0, 4'b1000, 0, 1, 1, 1, 0, 0, "A_round");
    step(0, 0, 4'b1000, 0, 2, 1, 0, 0, 0, "A_pulse_end");

    // Successor too early; fault freezes phase/dwell
    idle_step(0, 1, 4'b1000, "B_clr");
    step(0, 0, 4'b1000, 0, 1, 0, 0, 0, 0, "B_p0");
    step(0, 0, 4'b1000, 0, 2, 0, 0, 0, 0, "B_p0");
    step(0, 0, 4'b0100, 0, 2, 0, 0, 1, 3, "B_short");
    step(0, 0, 4'b1000, 0, 2, 0, 0, 1, 3, "B_frozen");

    // Exactly MAX_DWELL then leave: legal
    idle_step(0, 1, 4'b0000, "C_clr");
    for (int i = 0; i < 16; i++) step(0, 0, 4'b1000, 0, i + 1, 0, 0, 0, 0, "C_p0");
    step(0, 0, 4'b0100, 1, 1, 0, 0, 0, 0, "C_max_ok");

    // One sample past MAX_DWELL: too long
    idle_step(0, 1, 4'b0000, "C_clr2");
    for (int i = 0; i < 16; i++) step(0, 0, 4'b1000, 0, i + 1, 0, 0, 0, 0, "C_p0b");
    step(0, 0, 4'b1000, 0, 16, 0, 0, 1, 4, "C_long");
    step(0, 0, 4'b1000, 0, 16, 0, 0, 1, 4, "C_frozen");

    // Illegal from idle; first fault kept; clr recovers
    idle_step(0, 1, 4'b0000, "D_clr");
    step(0, 0, 4'b0110, 3, 0, 0, 0, 1, 1, "D_illegal");
    step(0, 0, 4'b0100, 3, 0, 0, 0, 1, 1, "D_keep_first");
    idle_step(0, 1, 4'b0100, "D_clr_recover");

    // ALL_ON from P1 goes idle; then P2 is a bad transition
    for (int i = 0; i < 3; i++) step(0, 0, 4'b1000, 0, i + 1, 0, 0, 0, 0, "E_p0");
    step(0, 0, 4'b0100, 1, 1, 0, 0, 0, 0, "E_p1");
    idle_step(0, 0, 4'b1111, "E_allon");
    step(0, 0, 4'b0010, 3, 0, 0, 0, 1, 2, "E_bad");

    // clr beats an illegal pattern at the same edge
    idle_step(0, 1, 4'b0110, "F_clr_prio");
    idle_step(0, 0, 4'b1111, "F_allon_idle");
    step(0, 0, 4'b1000, 0, 1, 0, 0, 0, 0, "F_p0");
    step(0, 0, 4'b1000, 0, 2, 0, 0, 0, 0, "F_p0");
    // reset overrides clr and light, and forgets the running P0
    idle_step(1, 1, 4'b1000, "F_res_prio");
    step(0, 0, 4'b0100, 3, 0, 0, 0, 1, 2, "F_reset_hist");
    idle_step(0, 1, 4'b0000, "F_clr");

    // 256 rounds: cycle_count saturates at 255
    for (int i = 0; i < 3; i++) step(0, 0, 4'b1000, 0, i + 1, 0, 0, 0, 0, "G_p0");
    for (int r = 0; r < 256; r++) begin
      int cc;
      cc = (r + 1 > 255) ? 255 : r + 1;
      for (int i = 0; i < 3; i++) step(0, 0, 4'b0100, 1, i + 1, cc - ((r + 1 > 255) ? 0 : 1), 0, 0, 0, "G_p1");
      for (int i = 0; i < 3; i++) step(0, 0, 4'b0010, 2, i + 1, cc - ((r + 1 > 255) ? 0 : 1), 0, 0, 0, "G_p2");
      step(0, 0, 4'b1000, 0, 1, cc, 1, 0, 0, "G_round");
      step(0, 0, 4'b1000, 0, 2, cc, 0, 0, 0, "G_p0");
      step(0, 0, 4'b1000, 0, 3, cc, 0, 0, 0, "G_p0");
    end

    // Let the monitor drain the queue
    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries left want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter MIN_DWELL, default 3, minimum legal cycles per lamp phase.
REQ-002 SHALL have parameter MAX_DWELL, default 16, maximum legal cycles per lamp phase; MAX_DWELL > MIN_DWELL >= 1.
REQ-003 SHALL have parameter CNT_W, default 8, width of dwell and cycle counters.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port res, input, 1, synchronous active-high reset.
REQ-006 SHALL have port light, input, 4, lamp pattern driven by the traffic controller.
REQ-007 SHALL have port clr, input, 1, synchronous clear of the sticky fault and counters.
REQ-008 SHALL have port phase, output, 2, current tracked phase: 0=P0, 1=P1, 2=P2, 3=idle/unsynced.
REQ-009 SHALL have port dwell, output, CNT_W, cycles spent in the current phase.
REQ-010 SHALL have port cycle_count, output, CNT_W, completed P0->P1->P2->P0 rounds, saturating.
REQ-011 SHALL have port cycle_done, output, 1, one-cycle pulse per completed round.
REQ-012 SHALL have port fault, output, 1, sticky fault flag.
REQ-013 SHALL have port fault_code, output, 3, cause of the first fault since the last clear.

Function
REQ-014 SHALL decode light: 1000=P0, 0100=P1, 0010=P2, 1111=ALL_ON; any other value is ILLEGAL.
REQ-015 SHALL implement FSM states IDLE, P0, P1, P2, FAULT; all outputs registered, reflecting the light sampled at the same edge (1-cycle latency).
REQ-016 IDLE: ALL_ON stays; P0 enters P0 with dwell=1; P1 or P2 enters FAULT code 2 (bad transition); ILLEGAL enters FAULT code 1.
REQ-017 Px with same pattern: dwell increments; if dwell == MAX_DWELL already, enter FAULT code 4 (too long).
REQ-018 Px with legal successor (P0->P1, P1->P2, P2->P0): if dwell < MIN_DWELL enter FAULT code 3 (too short); else enter successor with dwell=1.
REQ-019 Px with non-successor legal phase: FAULT code 2; with ILLEGAL: FAULT code 1; with ALL_ON: IDLE, dwell=0, no fault.
REQ-020 Accepted P2->P0 SHALL pulse cycle_done one cycle and increment cycle_count, saturating at all-ones without wrap.
REQ-021 FAULT: fault=1, fault_code and phase frozen at entry values, dwell frozen; light ignored until clr.
REQ-022 Fault codes: 0 none, 1 illegal pattern, 2 bad transition, 3 too short, 4 too long; only the first fault latched.
REQ-023 clr high in any state SHALL force IDLE, phase=3, dwell=0, cycle_count=0, fault=0, fault_code=0; clr takes priority over any fault detected at that edge; light at that edge is discarded.
REQ-024 dwell SHALL never wrap; MAX_DWELL < 2^CNT_W is a parameter legality rule.

Reset
REQ-025 res high at an edge SHALL give state IDLE, phase=3, dwell=0, cycle_count=0, cycle_done=0, fault=0, fault_code=0, overriding clr and light.
REQ-026 Reset mid-phase or mid-fault SHALL discard all history; the next accepted entry must again be P0.

Structure
REQ-027 Shared package traffic_light_pkg SHALL hold lamp encodings (shared with the controller), phase encoding, fault-code constants and FSM state typedef.
REQ-028 One sub-module traffic_dwell_counter SHALL hold the saturating dwell counter with load-1, hold, clear controls.

Verification
REQ-029 res, then light 1000x3, 0100x3, 0010x3, 1000 -> phases 0,1,2,0; cycle_done pulse on the last sample; cycle_count=1; fault=0.
REQ-030 In P0 with dwell=2 apply 0100 (MIN_DWELL=3) -> fault=1, fault_code=3, phase stays 0.
REQ-031 Hold 1000 for 17 cycles (MAX_DWELL=16) -> fault_code=4 on the 17th sample; dwell frozen at 16.
REQ-032 From IDLE apply 0110 -> fault_code=1; then 0100 -> fault_code unchanged; then clr -> fault=0, phase=3.
REQ-033 In P1 apply 1111 -> IDLE, no fault; then 0010 -> fault_code=2.
REQ-034 Assert clr and an illegal light at the same edge -> IDLE, fault=0; run 256 rounds -> cycle_count saturates at 255.
